nios2_oci_dct_trace_buffer: RTL

- Parametrised debug-capture-trace (DCT) buffer for the Nios II OCI simulation/test path.
- Captures trace words into a circular buffer of configurable width and depth, and tracks the fill count and overflow.
- On test end, drains the captured words over a valid/ready port, then raises test_has_ended.
- Successor to the fixed 30-bit, 4-bit-count DCT hook; adds real storage, drain handshake and selectable overflow policy.

---
 rtl/nios2_oci_dct_trace_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/nios2_oci_dct_trace_buffer.sv
// nios2_oci_dct_trace_buffer
// Debug-capture-trace buffer for the Nios II OCI test path. Trace words are
// captured into a circular buffer. On end of test the buffer is drained over a
// valid/ready port, and then test_has_ended is raised.
// Optional feature macro: OCI_DCT_TIMESTAMP_EN. When it is defined, each entry
// is tagged in its upper bits with a free-running TS_W-bit cycle stamp.
module nios2_oci_dct_trace_buffer #(
  parameter int DATA_W    = 30,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 1,
  parameter int TS_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         arm,
  input  logic                         trace_valid,
  input  logic [DATA_W-1:0]            trace_data,
  input  logic                         test_ending,
  input  logic                         rd_ready,
  output logic                         rd_valid,
`ifdef OCI_DCT_TIMESTAMP_EN
  output logic [TS_W+DATA_W-1:0]       rd_data,
`else
  output logic [DATA_W-1:0]            rd_data,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   dct_count,
  output logic                         dct_overflow,
  output logic                         test_has_ended
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int ENTRY_W = TS_W + DATA_W;
`else
  // TS_W has no effect when timestamps are not stored.
  localparam int ENTRY_W = DATA_W + 0 * TS_W;
`endif
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic                overflow_reg;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  wr_entry;

  logic full;
  logic clear_buf;
  logic cap_write;
  logic store;
  logic pop;

  assign full      = (count_reg == FULL_COUNT);
  // arm restarts capture from any state other than an ongoing drain
  assign clear_buf = arm && (state_reg != DRAIN);
  assign cap_write = (state_reg == CAPTURE) && trace_valid && !arm;
  // In drop mode, a write into a full buffer is discarded
  assign store     = cap_write && (!full || (WRAP_MODE != 0));
  assign pop       = (state_reg == DRAIN) && (count_reg != '0) && rd_ready;

`ifdef OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  // Free-running cycle stamp; arm does not restart it
  always_ff @(posedge clk) begin
    if (reset) ts_reg <= '0;
    else       ts_reg <= ts_reg + TS_W'(1);
  end

  assign wr_entry = {ts_reg, trace_data};
`else
  assign wr_entry = trace_data;
`endif

  // Storage array, written at wr_ptr; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr_reg] <= wr_entry;
  end

  // Pointers, fill count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset || clear_buf) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (cap_write) begin
        if (!full) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
          count_reg  <= count_reg + CW'(1);
        end else begin
          overflow_reg <= 1'b1;
          if (WRAP_MODE != 0) begin
            // Overwrite the oldest entry: both pointers move, count stays full
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
          end
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg  <= count_reg - CW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (arm)              state_next = CAPTURE;
        else if (test_ending) state_next = DRAIN;
      end
      CAPTURE: begin
        if (test_ending) state_next = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the buffer is empty or the final entry pops, so
        // test_has_ended is visible the cycle after the last pop
        if ((count_reg == '0) || (pop && (count_reg == CW'(1))))
          state_next = DONE;
      end
      DONE: begin
        if (arm) state_next = CAPTURE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: read port presents the oldest entry while draining
  always_comb begin
    rd_valid       = (state_reg == DRAIN) && (count_reg != '0);
    rd_data        = '0;
    if (rd_valid) rd_data = mem[rd_ptr_reg];
    test_has_ended = (state_reg == DONE);
  end

  assign dct_count    = count_reg;
  assign dct_overflow = overflow_reg;

endmodule
